// File: rtl/muldiv_pkg.sv
// Shared types and encodings for the multiply/divide sequencer.
package muldiv_pkg;

    // Sequencer states
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        MUL   = 3'd1,
        DIV   = 3'd2,
        WB_LO = 3'd3,
        WB_HI = 3'd4
    } state_e;

    // mul_funct encodings
    localparam logic [2:0] MF_MUL   = 3'b000;
    localparam logic [2:0] MF_MLA   = 3'b001;
    localparam logic [2:0] MF_UMULL = 3'b100;
    localparam logic [2:0] MF_UMLAL = 3'b101;
    localparam logic [2:0] MF_SMULL = 3'b110;
    localparam logic [2:0] MF_SMLAL = 3'b111;

    // For divides, this mul_funct bit selects SDIV (1) or UDIV (0)
    localparam int DIV_SIGNED_BIT = 0;

endpackage

// File: rtl/muldiv_sequencer_div_step.sv
// One restoring-divide iteration on unsigned magnitudes: shift the next
// dividend bit into the partial remainder, subtract the divisor if it fits,
// and shift the resulting quotient bit into the low end of quo.
module div_step
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_i,
    input  logic [WIDTH-1:0] quo_i,
    input  logic [WIDTH-1:0] div_i,
    output logic [WIDTH-1:0] rem_o,
    output logic [WIDTH-1:0] quo_o
);

    // Partial remainder is kept one bit wider so the shift cannot overflow
    logic [WIDTH:0] shifted;
    logic           fits;

    // Single restoring step
    always_comb begin
        shifted = {rem_i, quo_i[WIDTH-1]};
        fits    = (shifted >= {1'b0, div_i});
        rem_o   = fits ? WIDTH'(shifted - {1'b0, div_i}) : shifted[WIDTH-1:0];
        quo_o   = {quo_i[WIDTH-2:0], fits};
    end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multicycle multiply/divide sequencer: stalls the main FSM with busy,
// runs a fixed-latency multiply or a restoring divide, then emits one or
// two registered write-back words.
// Optional macro MULDIV_EARLY_EXIT_EN: finish a divide after its first
// cycle when the quotient is trivially zero.
module muldiv_sequencer
    import muldiv_pkg::*;
#(
    parameter int WIDTH    = 32,
    parameter int MUL_LAT  = 2,
    parameter int DIV_ITER = WIDTH
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             is_mul,
    input  logic             is_long_mul,
    input  logic             is_div,
    input  logic [2:0]       mul_funct,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] acc_hi,
    output logic             busy,
    output logic             wb_valid,
    output logic             wb_hi,
    output logic [WIDTH-1:0] wb_data,
    output logic             done
);

    localparam int CNT_W = $clog2(DIV_ITER + MUL_LAT + 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         funct_q, funct_d;
    logic               long_q, long_d;
    logic               neg_q, neg_d;
    logic [WIDTH-1:0]   a_q, a_d;       // multiplicand, or dividend/quotient shift register
    logic [WIDTH-1:0]   b_q, b_d;       // multiplier, or divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [2*WIDTH-1:0] res_q, res_d;
    logic               busy_q, busy_d;
    logic               wb_valid_q, wb_valid_d;
    logic               wb_hi_q, wb_hi_d;
    logic [WIDTH-1:0]   wb_data_q, wb_data_d;
    logic               done_q, done_d;

    logic signed [2*WIDTH-1:0] a_ext, b_ext;
    logic [2*WIDTH-1:0]        prod, mul_res;
    logic [WIDTH-1:0]          step_rem, step_quo;
    logic                      sdiv;

    // Absolute value of a possibly-signed operand
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sgn);
        return (sgn && v[WIDTH-1]) ? WIDTH'(-v) : v;
    endfunction

    // Negate the unsigned quotient when the operand signs differed
    function automatic logic [WIDTH-1:0] apply_sign(input logic [WIDTH-1:0] q, input logic neg);
        return neg ? WIDTH'(-q) : q;
    endfunction

    div_step #(.WIDTH(WIDTH)) u_div_step (
        .rem_i (rem_q),
        .quo_i (a_q),
        .div_i (b_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    // 2W-bit product (signed only for SMULL/SMLAL) plus optional accumulate
    always_comb begin
        a_ext   = (funct_q[2:1] == 2'b11) ? $signed({{WIDTH{a_q[WIDTH-1]}}, a_q})
                                          : $signed({{WIDTH{1'b0}}, a_q});
        b_ext   = (funct_q[2:1] == 2'b11) ? $signed({{WIDTH{b_q[WIDTH-1]}}, b_q})
                                          : $signed({{WIDTH{1'b0}}, b_q});
        prod    = a_ext * b_ext;
        mul_res = prod;
        if (funct_q == MF_MLA) begin
            mul_res = prod + {{WIDTH{1'b0}}, acc_q[WIDTH-1:0]};
        end else if (funct_q == MF_UMLAL || funct_q == MF_SMLAL) begin
            mul_res = prod + acc_q;
        end
    end

    // Next-state and registered-output logic
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        funct_d    = funct_q;
        long_d     = long_q;
        neg_d      = neg_q;
        a_d        = a_q;
        b_d        = b_q;
        rem_d      = rem_q;
        acc_d      = acc_q;
        res_d      = res_q;
        wb_valid_d = 1'b0;
        wb_hi_d    = 1'b0;
        wb_data_d  = wb_data_q;
        done_d     = 1'b0;
        sdiv       = mul_funct[DIV_SIGNED_BIT];

        case (state_q)
            IDLE: begin
                // busy_q is still high on the done cycle, so a start there is dropped
                if (start && !busy_q && (is_mul ^ is_div)) begin
                    funct_d = mul_funct;
                    long_d  = is_mul & is_long_mul;
                    acc_d   = {acc_hi, acc_lo};
                    rem_d   = '0;
                    res_d   = '0;
                    if (is_mul) begin
                        state_d = MUL;
                        cnt_d   = CNT_W'(MUL_LAT - 1);
                        a_d     = op_a;
                        b_d     = op_b;
                        neg_d   = 1'b0;
                    end else begin
                        state_d = DIV;
                        cnt_d   = CNT_W'(DIV_ITER - 1);
                        a_d     = magnitude(op_a, sdiv);
                        b_d     = magnitude(op_b, sdiv);
                        neg_d   = sdiv & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                    end
                end
            end
            MUL: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    res_d   = mul_res;
                    state_d = WB_LO;
                end
            end
            DIV: begin
                a_d   = step_quo;
                rem_d = step_rem;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == '0) begin
                    res_d   = {{WIDTH{1'b0}}, (b_q == '0) ? '0 : apply_sign(step_quo, neg_q)};
                    state_d = WB_LO;
                end
`ifdef MULDIV_EARLY_EXIT_EN
                // Zero divisor or |a| < |b|: the quotient is already known to be 0
                if (cnt_q == CNT_W'(DIV_ITER - 1) && (b_q == '0 || a_q < b_q)) begin
                    res_d   = '0;
                    state_d = WB_LO;
                end
`endif
            end
            WB_LO: begin
                wb_valid_d = 1'b1;
                wb_data_d  = res_q[WIDTH-1:0];
                if (long_q) begin
                    state_d = WB_HI;
                end else begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            WB_HI: begin
                wb_valid_d = 1'b1;
                wb_hi_d    = 1'b1;
                wb_data_d  = res_q[2*WIDTH-1:WIDTH];
                done_d     = 1'b1;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || wb_valid_d;
    end

    // State, datapath and output registers; reset aborts any operation
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            funct_q    <= '0;
            long_q     <= 1'b0;
            neg_q      <= 1'b0;
            a_q        <= '0;
            b_q        <= '0;
            rem_q      <= '0;
            acc_q      <= '0;
            res_q      <= '0;
            busy_q     <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_hi_q    <= 1'b0;
            wb_data_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            funct_q    <= funct_d;
            long_q     <= long_d;
            neg_q      <= neg_d;
            a_q        <= a_d;
            b_q        <= b_d;
            rem_q      <= rem_d;
            acc_q      <= acc_d;
            res_q      <= res_d;
            busy_q     <= busy_d;
            wb_valid_q <= wb_valid_d;
            wb_hi_q    <= wb_hi_d;
            wb_data_q  <= wb_data_d;
            done_q     <= done_d;
        end
    end

    assign busy     = busy_q;
    assign wb_valid = wb_valid_q;
    assign wb_hi    = wb_hi_q;
    assign wb_data  = wb_data_q;
    assign done     = done_q;

endmodule
